// File: rtl/segasys1_pkg.sv
// rtl/segasys1_pkg.sv - shared constants and types for the segasys1 sound command path
// Contents:
//   SNDCMD_PORT  main-CPU I/O port decoded upstream into SNDRQ
//   CLK_HZ       default system clock rate
//   nmi_state_t  sound-CPU NMI sequencer states
package segasys1_pkg;

    localparam logic [4:0] SNDCMD_PORT = 5'h18;
    localparam int         CLK_HZ      = 48_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } nmi_state_t;

endpackage

// File: rtl/segasys1_sndcmd_if.sv
// rtl/segasys1_sndcmd_if.sv - main-CPU / sound-CPU command bus bundle
// Signals:
//   SNDRQ, CPUDO  main-CPU write strobe and data (driven by master)
//   SNDRD         sound-CPU read strobe (driven by master)
//   SNDDO         command latch read data (driven by slave)
//   SNMI, SIRQ    sound-CPU interrupt requests (driven by slave)
//   CMDCNT        queue occupancy, CMDOVF sticky overflow (driven by slave)
interface segasys1_sndcmd_if #(
    parameter int DEPTH = 4
);
    logic                     SNDRQ;
    logic [7:0]               CPUDO;
    logic                     SNDRD;
    logic [7:0]               SNDDO;
    logic                     SNMI;
    logic                     SIRQ;
    logic [$clog2(DEPTH):0]   CMDCNT;
    logic                     CMDOVF;

    modport master (
        output SNDRQ, CPUDO, SNDRD,
        input  SNDDO, SNMI, SIRQ, CMDCNT, CMDOVF
    );

    modport slave (
        input  SNDRQ, CPUDO, SNDRD,
        output SNDDO, SNMI, SIRQ, CMDCNT, CMDOVF
    );
endinterface

// File: rtl/segasys1_cmdfifo.sv
// rtl/segasys1_cmdfifo.sv - small command FIFO with registered head output
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and data
//   pop            read request (ignored when empty)
//   full, empty    occupancy flags
//   count          number of stored entries
//   head           registered copy of the oldest entry; holds last value when empty
module segasys1_cmdfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot, so a push into a full queue is
    // still accepted; a pop on an empty queue is simply ignored.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            head  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Head follows the read pointer one cycle after any change; a drained
            // queue keeps presenting the last command.
            if (!empty) begin
                head <= mem[rptr];
            end
        end
    end
endmodule

// File: rtl/segasys1_sndcmd.sv
// rtl/segasys1_sndcmd.sv - sound command bridge: command queue, NMI sequencer, periodic IRQ
// Ports:
//   CLK48M   system clock
//   RESETn   asynchronous active-low reset
//   bus      segasys1_sndcmd_if slave: SNDRQ/CPUDO/SNDRD in, SNDDO/SNMI/SIRQ/CMDCNT/CMDOVF out
module segasys1_sndcmd
    import segasys1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NMI_GAP = 16,
    parameter int IRQ_DIV = 200000,
    parameter int IRQ_LEN = 192
) (
    input  logic               CLK48M,
    input  logic               RESETn,
    segasys1_sndcmd_if.slave   bus
);
    localparam int GW = $clog2(NMI_GAP);
    localparam int IW = $clog2(IRQ_DIV);

    logic [1:0]            rq_sync;
    logic [1:0]            rd_sync;
    logic                  rq_prev;
    logic                  rd_prev;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [$clog2(DEPTH):0] cmd_cnt;
    logic [7:0]            head;
    logic                  ovf;
    nmi_state_t            nmi_state;
    logic                  snmi;
    logic [GW-1:0]         gap_cnt;
    logic [IW-1:0]         irq_cnt;
    logic                  sirq;

    // Strobes are slow levels from the 3 MHz side; two flops for metastability,
    // a third for the rising-edge detect, so each level yields one pulse.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            rq_sync <= '0;
            rd_sync <= '0;
            rq_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            rq_sync <= {rq_sync[0], bus.SNDRQ};
            rd_sync <= {rd_sync[0], bus.SNDRD};
            rq_prev <= rq_sync[1];
            rd_prev <= rd_sync[1];
        end
    end

    assign push = rq_sync[1] && !rq_prev;
    assign pop  = rd_sync[1] && !rd_prev;

    segasys1_cmdfifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK48M),
        .rst_n (RESETn),
        .push  (push),
        .pop   (pop),
        .din   (bus.CPUDO),
        .full  (full),
        .empty (empty),
        .count (cmd_cnt),
        .head  (head)
    );

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            ovf <= 1'b0;
        end else if (push && full && !pop) begin
            ovf <= 1'b1;
        end
    end

    // One NMI rising edge per queued command: held high until the sound CPU
    // reads, then forced low for NMI_GAP cycles so the next edge is seen.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            nmi_state <= IDLE;
            snmi      <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            case (nmi_state)
                IDLE: begin
                    if (!empty) begin
                        nmi_state <= ASSERT;
                        snmi      <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (pop && !empty) begin
                        nmi_state <= GAP;
                        snmi      <= 1'b0;
                        gap_cnt   <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(NMI_GAP - 1)) begin
                        if (!empty) begin
                            nmi_state <= ASSERT;
                            snmi      <= 1'b1;
                        end else begin
                            nmi_state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    nmi_state <= IDLE;
                    snmi      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            irq_cnt <= '0;
            sirq    <= 1'b0;
        end else begin
            irq_cnt <= (irq_cnt == IW'(IRQ_DIV - 1)) ? '0 : irq_cnt + IW'(1);
            sirq    <= (irq_cnt < IW'(IRQ_LEN));
        end
    end

    assign bus.SNDDO  = head;
    assign bus.SNMI   = snmi;
    assign bus.SIRQ   = sirq;
    assign bus.CMDCNT = cmd_cnt;
    assign bus.CMDOVF = ovf;
endmodule

// File: tb/tb_segasys1_sndcmd.sv
// tb/tb_segasys1_sndcmd.sv - scoreboard bench for the sound command bridge
module tb_segasys1_sndcmd;
    localparam int DEPTH   = 4;
    localparam int NMI_GAP = 16;
    localparam int IRQ_DIV = 400;
    localparam int IRQ_LEN = 24;

    logic CLK48M = 1'b0;
    logic RESETn = 1'b0;

    segasys1_sndcmd_if #(.DEPTH(DEPTH)) bus ();

    segasys1_sndcmd #(
        .DEPTH   (DEPTH),
        .NMI_GAP (NMI_GAP),
        .IRQ_DIV (IRQ_DIV),
        .IRQ_LEN (IRQ_LEN)
    ) dut (
        .CLK48M (CLK48M),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK48M = ~CLK48M;

    int        n_cmp = 0;
    int        n_bad = 0;
    logic [7:0] exp_q[$];
    logic      snmi_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every SNMI rising edge presents one command on SNDDO.
    always @(negedge CLK48M) begin
        if (!RESETn) begin
            snmi_prev = 1'b0;
        end else begin
            if (bus.SNMI && !snmi_prev) begin
                if (exp_q.size() == 0) begin
                    check("nmi_unexpected", 32'(bus.SNDDO), 32'hFFFF_FFFF);
                end else begin
                    check("nmi_data", 32'(bus.SNDDO), 32'(exp_q.pop_front()));
                end
            end
            snmi_prev = bus.SNMI;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        RESETn = 1'b0;
        bus.SNDRQ = 1'b0;
        bus.SNDRD = 1'b0;
        bus.CPUDO = 8'h00;
        repeat (2) @(negedge CLK48M);
        exp_q.delete();
        RESETn = 1'b1;
    endtask

    task automatic push_cmd(input logic [7:0] d, input bit accepted);
        @(negedge CLK48M);
        bus.CPUDO = d;
        bus.SNDRQ = 1'b1;
        if (accepted) exp_q.push_back(d);
        repeat (4) @(negedge CLK48M);
        bus.SNDRQ = 1'b0;
        repeat (4) @(negedge CLK48M);
    endtask

    // Sound-CPU read: wait for NMI, strobe SNDRD, then measure the low time
    // until the next NMI (capped at 40 when none follows).
    task automatic read_cmd(output int gap);
        int t;
        t = 0;
        while (!bus.SNMI && t < 200) begin
            @(negedge CLK48M);
            t++;
        end
        check("read_wait_nmi", 32'(bus.SNMI), 32'd1);
        bus.SNDRD = 1'b1;
        t = 0;
        while (bus.SNMI && t < 10) begin
            @(negedge CLK48M);
            t++;
        end
        check("read_nmi_drop", 32'(bus.SNMI), 32'd0);
        bus.SNDRD = 1'b0;
        gap = 0;
        while (!bus.SNMI && gap < 40) begin
            @(negedge CLK48M);
            gap++;
        end
    endtask

    initial begin
        int gap;
        int hi1;
        int hi2;
        int nmi_hi;
        bus.SNDRQ = 1'b0;
        bus.SNDRD = 1'b0;
        bus.CPUDO = 8'h00;

        // Test 1: reset state and single push from a long strobe
        do_reset();
        check("rst_snddo", 32'(bus.SNDDO), 32'h00);
        check("rst_snmi", 32'(bus.SNMI), 32'd0);
        check("rst_cmdcnt", 32'(bus.CMDCNT), 32'd0);
        check("rst_cmdovf", 32'(bus.CMDOVF), 32'd0);
        @(negedge CLK48M);
        bus.CPUDO = 8'hA5;
        bus.SNDRQ = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (2) @(negedge CLK48M);
        check("t1_cnt_before_push", 32'(bus.CMDCNT), 32'd0);
        @(negedge CLK48M);
        check("t1_cnt_after_push", 32'(bus.CMDCNT), 32'd1);
        check("t1_snmi_not_yet", 32'(bus.SNMI), 32'd0);
        @(negedge CLK48M);
        check("t1_snmi_rise", 32'(bus.SNMI), 32'd1);
        check("t1_snddo", 32'(bus.SNDDO), 32'hA5);
        repeat (13) @(negedge CLK48M);
        bus.SNDRQ = 1'b0;
        check("t1_single_push", 32'(bus.CMDCNT), 32'd1);
        read_cmd(gap);
        check("t1_no_more_nmi", 32'(gap), 32'd40);

        // Test 2: three commands read back in order with NMI gaps
        push_cmd(8'h01, 1'b1);
        push_cmd(8'h02, 1'b1);
        push_cmd(8'h03, 1'b1);
        check("t2_cnt3", 32'(bus.CMDCNT), 32'd3);
        read_cmd(gap);
        check("t2_gap1", 32'(gap), 32'(NMI_GAP));
        read_cmd(gap);
        check("t2_gap2", 32'(gap), 32'(NMI_GAP));
        read_cmd(gap);
        check("t2_idle", 32'(gap), 32'd40);
        check("t2_cnt0", 32'(bus.CMDCNT), 32'd0);
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // Test 3: overflow drops the fifth command
        push_cmd(8'h10, 1'b1);
        push_cmd(8'h11, 1'b1);
        push_cmd(8'h12, 1'b1);
        push_cmd(8'h13, 1'b1);
        push_cmd(8'h14, 1'b0);
        check("t3_cnt_full", 32'(bus.CMDCNT), 32'd4);
        check("t3_ovf", 32'(bus.CMDOVF), 32'd1);
        for (int i = 0; i < 4; i++) read_cmd(gap);
        check("t3_cnt0", 32'(bus.CMDCNT), 32'd0);
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // Test 5: read of an empty latch
        check("t5_snddo_hold", 32'(bus.SNDDO), 32'h13);
        @(negedge CLK48M);
        bus.SNDRD = 1'b1;
        nmi_hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK48M);
            if (i == 5) bus.SNDRD = 1'b0;
            if (bus.SNMI) nmi_hi++;
        end
        check("t5_cnt0", 32'(bus.CMDCNT), 32'd0);
        check("t5_snddo_hold2", 32'(bus.SNDDO), 32'h13);
        check("t5_no_nmi", 32'(nmi_hi), 32'd0);

        // Test 4: simultaneous push and pop on a full queue
        do_reset();
        check("t4_ovf_cleared", 32'(bus.CMDOVF), 32'd0);
        push_cmd(8'h20, 1'b1);
        push_cmd(8'h21, 1'b1);
        push_cmd(8'h22, 1'b1);
        push_cmd(8'h23, 1'b1);
        check("t4_cnt_full", 32'(bus.CMDCNT), 32'd4);
        @(negedge CLK48M);
        bus.CPUDO = 8'h24;
        bus.SNDRQ = 1'b1;
        bus.SNDRD = 1'b1;
        exp_q.push_back(8'h24);
        repeat (3) @(negedge CLK48M);
        check("t4_cnt_still_full", 32'(bus.CMDCNT), 32'd4);
        check("t4_no_ovf", 32'(bus.CMDOVF), 32'd0);
        check("t4_snmi_gap", 32'(bus.SNMI), 32'd0);
        repeat (3) @(negedge CLK48M);
        bus.SNDRQ = 1'b0;
        bus.SNDRD = 1'b0;
        repeat (4) @(negedge CLK48M);
        for (int i = 0; i < 4; i++) read_cmd(gap);
        check("t4_cnt0", 32'(bus.CMDCNT), 32'd0);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // Test 6: periodic IRQ, then asynchronous reset mid-queue
        do_reset();
        check("t6_sirq_rst", 32'(bus.SIRQ), 32'd0);
        hi1 = 0;
        hi2 = 0;
        for (int i = 0; i < 2 * IRQ_DIV; i++) begin
            @(negedge CLK48M);
            if (i == 0) check("t6_sirq_first", 32'(bus.SIRQ), 32'd1);
            if (bus.SIRQ) begin
                if (i < IRQ_DIV) hi1++;
                else hi2++;
            end
        end
        check("t6_sirq_len1", 32'(hi1), 32'(IRQ_LEN));
        check("t6_sirq_len2", 32'(hi2), 32'(IRQ_LEN));
        push_cmd(8'h31, 1'b1);
        push_cmd(8'h32, 1'b1);
        @(posedge CLK48M);
        #2;
        RESETn = 1'b0;
        #1;
        check("t6_async_snddo", 32'(bus.SNDDO), 32'h00);
        check("t6_async_snmi", 32'(bus.SNMI), 32'd0);
        check("t6_async_sirq", 32'(bus.SIRQ), 32'd0);
        check("t6_async_cnt", 32'(bus.CMDCNT), 32'd0);
        check("t6_async_ovf", 32'(bus.CMDOVF), 32'd0);
        do_reset();
        repeat (40) @(negedge CLK48M);
        check("t6_discarded", 32'(bus.CMDCNT), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
